// File: rtl/rr_arb8_16b.sv
// rtl/rr_arb8_16b.sv - round-robin 8:1 16-bit arbiter with registered valid/ready output stage
//
// Purpose: picks at most one of eight requesters per cycle (round-robin,
// search starting after the last winner), steers its word through an 8:1
// 16-bit mux and captures it in a one-entry output register.
//
// Optional feature macro: ARB8_LOCK_EN (burst lock; lock port ignored when undefined).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req[7:0]   request per requester, held until granted
//   in0..in7   16-bit requester data
//   lock[7:0]  burst-lock request per requester
//   gnt[7:0]   one-hot grant (combinational)
//   sel[2:0]   encoded winner / mux select (combinational)
//   out_valid  output register holds a word
//   out_ready  consumer accepts the word
//   out_data   registered selected word
//   out_src    registered index of the requester behind out_data

module rr_arb8_16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic [15:0] in3,
  input  logic [15:0] in4,
  input  logic [15:0] in5,
  input  logic [15:0] in6,
  input  logic [15:0] in7,
  input  logic [7:0]  lock,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_src
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic        take;
  logic        rr_hit;
  logic [2:0]  rr_idx;
  logic [2:0]  cand;
  logic        grant;
  logic [2:0]  win;
  logic [15:0] mux_data;

  assign out_valid = (state == FULL);

  // The output register can accept a word when empty or when draining this cycle.
  assign take = (state == EMPTY) || out_ready;

  // Rotating priority search: ptr+1, ptr+2, ... ptr+8 (= ptr itself, last).
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = 3'd0;
    cand   = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!rr_hit && req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

`ifdef ARB8_LOCK_EN
  // burst is set when the last grant (to requester ptr) was made with its
  // lock bit high; while set and that requester still asks, it wins again.
  logic burst;
  logic lock_win;

  assign lock_win = burst && req[ptr];

  always_comb begin
    grant = 1'b0;
    win   = 3'd0;
    if (!rst && take) begin
      if (lock_win) begin
        grant = 1'b1;
        win   = ptr;
      end else if (rr_hit) begin
        grant = 1'b1;
        win   = rr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst <= 1'b0;
    end else if (grant) begin
      burst <= lock[win];
    end else if (burst && !req[ptr]) begin
      // locked requester withdrew before being served again: burst over
      burst <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  always_comb begin
    grant = 1'b0;
    win   = 3'd0;
    if (!rst && take && rr_hit) begin
      grant = 1'b1;
      win   = rr_idx;
    end
  end
`endif

  assign gnt = grant ? (8'b0000_0001 << win) : 8'h00;
  assign sel = grant ? win : 3'd0;

  always_comb begin
    mux_data = 16'h0000;
    case (sel)
      3'd0: mux_data = in0;
      3'd1: mux_data = in1;
      3'd2: mux_data = in2;
      3'd3: mux_data = in3;
      3'd4: mux_data = in4;
      3'd5: mux_data = in5;
      3'd6: mux_data = in6;
      3'd7: mux_data = in7;
      default: mux_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= 16'h0000;
      out_src  <= 3'd0;
      ptr      <= 3'd7;
    end else begin
      if (grant) begin
        // also covers drain-and-refill in the same cycle: no bubble
        state    <= FULL;
        out_data <= mux_data;
        out_src  <= sel;
        ptr      <= sel;
      end else if (state == FULL && out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb8_16b.sv
// tb/tb_rr_arb8_16b.sv - directed self-checking bench for rr_arb8_16b

module tb_rr_arb8_16b;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [15:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [7:0]  lock;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_src;

  int checks = 0;
  int errors = 0;

  rr_arb8_16b dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .in5       (in5),
    .in6       (in6),
    .in7       (in7),
    .lock      (lock),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_g;

  initial begin
    rst = 1'b1;
    req = 8'h00;
    lock = 8'h00;
    out_ready = 1'b0;
    in0 = 16'h1000; in1 = 16'h1001; in2 = 16'h1002; in3 = 16'h1003;
    in4 = 16'h1004; in5 = 16'h1005; in6 = 16'h1006; in7 = 16'h1007;

    #3;
    chk("rst_gnt", 16'(gnt), 16'h00);
    chk("rst_sel", 16'(sel), 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_src", 16'(out_src), 16'h0);

    // full rotation with every requester pending
    #4;
    rst = 1'b0;
    req = 8'hFF;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i <= 8; i++) begin
      exp_g = 8'h01 << (i % 8);
      chk($sformatf("rot_gnt%0d", i), 16'(gnt), 16'(exp_g));
      if (i > 0) begin
        chk($sformatf("rot_data%0d", i), out_data, 16'h1000 + 16'((i - 1) % 8));
        chk($sformatf("rot_valid%0d", i), 16'(out_valid), 16'h1);
      end
      step();
    end
    chk("rot_data_last", out_data, 16'h1000);

    // drain
    req = 8'h00;
    #1;
    chk("drain_gnt", 16'(gnt), 16'h00);
    step();
    chk("drain_valid", 16'(out_valid), 16'h0);

    // bring ptr to 2, then wrap-around case
    req = 8'h04;
    #1;
    chk("p2_gnt", 16'(gnt), 16'h04);
    step();
    req = 8'h84;
    #1;
    chk("wrap_gnt7", 16'(gnt), 16'h80);
    chk("wrap_sel7", 16'(sel), 16'h7);
    step();
    chk("wrap_src7", 16'(out_src), 16'h7);
    req = 8'h04;
    #1;
    chk("wrap_gnt2", 16'(gnt), 16'h04);
    step();
    chk("wrap_src2", 16'(out_src), 16'h2);
    chk("wrap_data2", out_data, 16'h1002);
    req = 8'h00;
    step();
    chk("wrap_drain", 16'(out_valid), 16'h0);

    // backpressure
    req = 8'h01;
    #1;
    chk("bp_gnt0", 16'(gnt), 16'h01);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall_gnt%0d", i), 16'(gnt), 16'h00);
      chk($sformatf("bp_stall_valid%0d", i), 16'(out_valid), 16'h1);
      chk($sformatf("bp_stall_data%0d", i), out_data, 16'h1000);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_gnt", 16'(gnt), 16'h01);
    step();
    chk("bp_resume_valid", 16'(out_valid), 16'h1);
    chk("bp_resume_src", 16'(out_src), 16'h0);

    // drain and grant in the same cycle
    req = 8'h10;
    #1;
    chk("dg_gnt", 16'(gnt), 16'h10);
    step();
    chk("dg_valid", 16'(out_valid), 16'h1);
    chk("dg_src", 16'(out_src), 16'h4);
    chk("dg_data", out_data, 16'h1004);

    // async reset mid-transfer
    req = 8'hFF;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(out_valid), 16'h0);
    chk("arst_data", out_data, 16'h0000);
    out_ready = 1'b1;
    #1;
    chk("arst_gnt", 16'(gnt), 16'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_first_gnt", 16'(gnt), 16'h01);
    step();
    chk("arst_first_src", 16'(out_src), 16'h0);

    // burst lock sequence (fresh reset so requester 0 has top priority)
    req = 8'h00;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
    req = 8'h05;
    for (int g = 0; g < 4; g++) begin
      lock = (g < 3) ? 8'h01 : 8'h00;
      #1;
`ifdef ARB8_LOCK_EN
      exp_g = 8'h01;
`else
      exp_g = (g % 2 == 0) ? 8'h01 : 8'h04;
`endif
      chk($sformatf("lock_gnt%0d", g), 16'(gnt), 16'(exp_g));
      step();
    end
`ifdef ARB8_LOCK_EN
    #1;
    chk("lock_gnt4", 16'(gnt), 16'h04);
`endif
    lock = 8'h00;
    req = 8'h00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
